aes_block_loader: RTL and testbench
===================================

Name: aes_block_loader

Overview:
- Upstream feeder for the AES core and its state-observing logic.
- Accepts a 128-bit plaintext block as four 32-bit words over a valid/ready stream and assembles it in a shadow buffer.
- Commits the block atomically to the `state` bus, issues a one-cycle `start` to the core, then holds the core result until the consumer takes it.
- Downstream logic sees only whole, committed blocks on `state`, never partial words.

Parameters:
- BLOCK_W, 128, block width in bits; fixed, not overridable.
- WORD_W, 32, input word width; WORDS = BLOCK_W/WORD_W = 4.
- CNT_W, 16, width of the completed-block counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset; synchronous, active-high.
- in_data  input  32  plaintext word; first word accepted becomes bits [127:96].
- in_valid  input  1  in_data valid.
- in_ready  output  1  loader can accept a word.
- state  output  128  committed plaintext block to the core and observers.
- start  output  1  one-cycle pulse: core begins on `state`.
- core_done  input  1  core result valid (single-cycle pulse).
- core_result  input  128  ciphertext from the core.
- out_data  output  128  held ciphertext.
- out_valid  output  1  out_data valid.
- out_ready  input  1  consumer accepts out_data.
- busy  output  1  high in START and WAIT.
- block_count  output  CNT_W  number of completed output handshakes; wraps to 0 after all-ones.

Behaviour:
- Reset values:
  - state = 0, out_data = 0, buffer = 0, word index = 0, block_count = 0.
  - start = 0, out_valid = 0, busy = 0.
  - FSM = FILL, so in_ready = 1 in the first cycle after reset.
- Reset mid-operation (any state) abandons the current block. No start or out_valid is produced for it.
- FSM states: FILL, START, WAIT, OUT.
- FILL:
  - in_ready = 1.
  - A word is accepted when in_valid && in_ready. It goes to buffer word[idx], where idx 0 maps to [127:96] and idx 3 maps to [31:0]; idx then increments.
  - `state` is unchanged while idx < 3.
  - On acceptance of word idx 3:
    - state <= {buffer[127:32], in_data} in the same edge.
    - idx <= 0.
    - next state START.
  - in_valid low leaves everything held. Gaps between words are allowed with no timeout.
- START:
  - start = 1 for exactly this one cycle; in_ready = 0; busy = 1.
  - Next state WAIT unconditionally.
- WAIT:
  - in_ready = 0; busy = 1.
  - On core_done: out_data <= core_result; next state OUT.
  - state is held stable for the whole WAIT period.
- core_done outside WAIT is ignored. This includes the START cycle and assertion in the same cycle as start.
- OUT:
  - out_valid = 1; out_data is stable; in_ready = 0.
  - On out_valid && out_ready: block_count increments (wrapping) and next state is FILL.
  - out_valid falls in the following cycle.
- Throughput:
  - Minimum 4 input cycles + 1 START + core latency + 1 OUT cycle per block.
  - No overlap: input is not accepted until the output handshake completes.
- `state` keeps the last committed block after OUT and through the next FILL, until the next 4th-word commit.
- Latency from 4th word accepted to start high: 1 cycle (start asserted in the cycle after acceptance, together with the new `state`).

Decomposition:
- Package aes_loader_pkg holds:
  - BLOCK_W, WORD_W, WORDS, the index width $clog2(WORDS).
  - The FSM enum loader_state_t {FILL, START, WAIT, OUT}.
- No sub-module is required.
- Word packing is a few lines inside the block; split it into aes_word_packer only if a second user appears.

Test Plan:
- Reset, then check idle outputs: in_ready = 1, state = 0, start = 0, out_valid = 0, block_count = 0.
- FIPS-197 vector, back-to-back words 00112233, 44556677, 8899aabb, ccddeeff:
  - state = 00112233_44556677_8899aabb_ccddeeff exactly one cycle after word 4, with start high that cycle only.
  - state never shows a partial block earlier.
  - Then a core model returns 69c4e0d8_6a7b0430_d8cdb780_70b4c55a after 10 cycles: out_valid = 1 and out_data equals that value.
- Gaps and backpressure:
  - in_valid toggled randomly during fill gives the same committed state.
  - out_ready held low 5 cycles keeps out_data and out_valid stable and in_ready = 0.
  - After the handshake, block_count = 1.
- Spurious core_done in FILL and in the START cycle: no capture, FSM stays on path, out_valid stays 0 until core_done in WAIT.
- Reset asserted after word 2, and separately during WAIT: next block loads cleanly from idx 0, no stray start or out_valid, state = 0 until the first commit.
- Counter wrap: preload via 65536 handshakes (or CNT_W = 2 override for the sim) and check block_count wraps to 0.

Source files
------------

// File: rtl/aes_loader_pkg.sv
// aes_loader_pkg: shared widths and FSM states for the AES block loader
package aes_loader_pkg;
  localparam int BLOCK_W = 128;
  localparam int WORD_W = 32;
  localparam int WORDS = BLOCK_W / WORD_W;
  localparam int IDX_W = $clog2(WORDS);
  typedef enum logic [1:0] {FILL, START, WAIT, OUT} loader_state_t;
endpackage

// File: rtl/aes_block_loader.sv
// aes_block_loader: assembles four words into a block, commits it atomically to the core and holds the result
module aes_block_loader
  import aes_loader_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WORD_W-1:0]  in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [BLOCK_W-1:0] state,
  output logic               start,
  input  logic               core_done,
  input  logic [BLOCK_W-1:0] core_result,
  output logic [BLOCK_W-1:0] out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               busy,
  output logic [CNT_W-1:0]   block_count
);
  loader_state_t st_q;
  logic [WORDS-1:0][WORD_W-1:0] buf_q;
  logic [IDX_W-1:0] idx_q;
  logic [BLOCK_W-1:0] state_q, out_q;
  logic in_ready_q, start_q, out_valid_q, busy_q;
  logic [CNT_W-1:0] cnt_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q        <= FILL;
      buf_q       <= '0;
      idx_q       <= '0;
      state_q     <= '0;
      out_q       <= '0;
      in_ready_q  <= 1'b1;
      start_q     <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      cnt_q       <= '0;
    end else begin
      case (st_q)
        FILL: if (in_valid) begin
          // idx 0 lands in the top word, so the buffer is filled from the MSB down
          buf_q[~idx_q] <= in_data;
          idx_q         <= idx_q + 1'b1;
          if (idx_q == IDX_W'(WORDS - 1)) begin
            state_q    <= {buf_q[WORDS-1:1], in_data};
            st_q       <= START;
            start_q    <= 1'b1;
            busy_q     <= 1'b1;
            in_ready_q <= 1'b0;
          end
        end
        START: begin
          start_q <= 1'b0;
          st_q    <= WAIT;
        end
        WAIT: if (core_done) begin
          out_q       <= core_result;
          out_valid_q <= 1'b1;
          busy_q      <= 1'b0;
          st_q        <= OUT;
        end
        OUT: if (out_ready) begin
          cnt_q       <= cnt_q + 1'b1;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          st_q        <= FILL;
        end
      endcase
    end
  end
  assign in_ready    = in_ready_q;
  assign state       = state_q;
  assign start       = start_q;
  assign out_data    = out_q;
  assign out_valid   = out_valid_q;
  assign busy        = busy_q;
  assign block_count = cnt_q;
endmodule

// File: tb/tb_aes_block_loader.sv
// tb_aes_block_loader: scoreboard bench for aes_block_loader with directed blocks
module tb_aes_block_loader;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] in_data;
  logic in_valid, in_ready, start, core_done, out_valid, out_ready, busy;
  logic [127:0] state, core_result, out_data;
  logic [1:0] block_count;
  always #5 clk = ~clk;
  aes_block_loader #(.CNT_W(2)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .state(state), .start(start), .core_done(core_done), .core_result(core_result),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .busy(busy),
    .block_count(block_count)
  );
  localparam logic [127:0] PT1 = 128'h00112233_44556677_8899aabb_ccddeeff;
  localparam logic [127:0] CT1 = 128'h69c4e0d8_6a7b0430_d8cdb780_70b4c55a;
  int n_cmp = 0;
  int n_err = 0;
  logic [127:0] exp_state_q[$];
  logic [127:0] exp_out_q[$];
  logic [1:0] exp_cnt = '0;
  logic [127:0] prev_state = '0;
  logic rst_d = 1'b1;
  logic start_d = 1'b0;
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (rst) exp_cnt = '0;
    if (rst || rst_d) prev_state = state;
    else begin
      if (start) begin
        if (exp_state_q.size() == 0) chk("stray_start", {127'b0, start}, 128'd0);
        else chk("commit_state", state, exp_state_q.pop_front());
        if (start_d) chk("start_width", {127'b0, start}, 128'd0);
      end else if (state !== prev_state) chk("partial_state", state, prev_state);
      if (out_valid && exp_out_q.size() == 0) chk("stray_out_valid", {127'b0, out_valid}, 128'd0);
      else if (out_valid && out_ready) begin
        chk("out_data", out_data, exp_out_q.pop_front());
        exp_cnt = exp_cnt + 1'b1;
      end
      prev_state = state;
    end
    rst_d = rst;
    start_d = start;
  end
  task automatic send_word(input logic [31:0] w, input int gap);
    int t;
    in_valid = 1'b0;
    repeat (gap) begin
      in_data = $urandom;
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_data = w;
    t = 0;
    while (!in_ready && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    if (!in_ready) chk("in_ready_timeout", 128'd0, 128'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask
  task automatic send_block(input logic [127:0] b, input bit gaps);
    exp_state_q.push_back(b);
    for (int i = 0; i < 4; i++) send_word(b[127-32*i -: 32], gaps ? int'($urandom_range(0, 2)) : 0);
  endtask
  task automatic core_resp(input logic [127:0] r, input int lat);
    repeat (lat) @(posedge clk);
    #1;
    exp_out_q.push_back(r);
    core_done = 1'b1;
    core_result = r;
    @(posedge clk); #1;
    core_done = 1'b0;
    core_result = $urandom;
  endtask
  task automatic consume(input int hold);
    int t;
    logic [127:0] e;
    t = 0;
    while (!out_valid && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    if (!out_valid) chk("out_valid_timeout", 128'd0, 128'd1);
    e = exp_out_q.size() ? exp_out_q[0] : 128'd0;
    repeat (hold) begin
      @(posedge clk); #1;
      chk("hold_data", out_data, e);
      chk("hold_valid", {127'b0, out_valid}, 128'd1);
      chk("hold_in_ready", {127'b0, in_ready}, 128'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("out_valid_fall", {127'b0, out_valid}, 128'd0);
    chk("in_ready_back", {127'b0, in_ready}, 128'd1);
  endtask
  task automatic pulse_rst();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_state", state, 128'd0);
    chk("rst_in_ready", {127'b0, in_ready}, 128'd1);
    chk("rst_cnt", {126'b0, block_count}, 128'd0);
    chk("rst_out_valid", {127'b0, out_valid}, 128'd0);
    chk("rst_busy", {127'b0, busy}, 128'd0);
  endtask
  initial begin
    in_valid = 1'b0;
    in_data = '0;
    core_done = 1'b0;
    core_result = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", {127'b0, in_ready}, 128'd1);
    chk("idle_state", state, 128'd0);
    chk("idle_start", {127'b0, start}, 128'd0);
    chk("idle_out_valid", {127'b0, out_valid}, 128'd0);
    chk("idle_cnt", {126'b0, block_count}, 128'd0);
    send_block(PT1, 1'b0);
    chk("fips_start", {127'b0, start}, 128'd1);
    chk("fips_state", state, PT1);
    chk("fips_busy", {127'b0, busy}, 128'd1);
    core_resp(CT1, 10);
    chk("fips_out_valid", {127'b0, out_valid}, 128'd1);
    chk("fips_out_data", out_data, CT1);
    consume(0);
    chk("cnt_1", {126'b0, block_count}, 128'd1);
    chk("state_kept", state, PT1);
    send_block(128'hdeadbeef_01234567_89abcdef_a5a5a5a5, 1'b1);
    core_resp(128'h0f0e0d0c_0b0a0908_07060504_03020100, 3);
    consume(5);
    chk("cnt_2", {126'b0, block_count}, 128'd2);
    core_done = 1'b1;
    core_result = 128'hbad0;
    @(posedge clk); #1;
    core_done = 1'b0;
    chk("spur_fill_out_valid", {127'b0, out_valid}, 128'd0);
    chk("spur_fill_in_ready", {127'b0, in_ready}, 128'd1);
    send_block(128'h11111111_22222222_33333333_44444444, 1'b0);
    core_done = 1'b1;
    core_result = 128'hbad1;
    @(posedge clk); #1;
    core_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("spur_start_out_valid", {127'b0, out_valid}, 128'd0);
    chk("spur_start_busy", {127'b0, busy}, 128'd1);
    core_resp(128'h55555555_66666666_77777777_88888888, 1);
    consume(0);
    chk("cnt_3", {126'b0, block_count}, 128'd3);
    send_word(32'hcafef00d, 0);
    send_word(32'h12345678, 0);
    pulse_rst();
    send_block(128'haaaaaaaa_bbbbbbbb_cccccccc_dddddddd, 1'b0);
    chk("post_rst_state", state, 128'haaaaaaaa_bbbbbbbb_cccccccc_dddddddd);
    core_resp(128'h99999999_88888888_77777777_66666666, 2);
    consume(0);
    chk("post_rst_cnt", {126'b0, block_count}, 128'd1);
    send_block(128'h0badc0de_0badc0de_0badc0de_0badc0de, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    pulse_rst();
    repeat (20) @(posedge clk);
    #1;
    chk("wait_rst_out_valid", {127'b0, out_valid}, 128'd0);
    chk("wait_rst_state", state, 128'd0);
    for (int i = 0; i < 4; i++) begin
      send_block({4{8'(i), 24'h5a5a5a}}, 1'b0);
      core_resp({4{32'(i * 7 + 1)}}, 2);
      consume(0);
      if (i == 2) chk("cnt_pre_wrap", {126'b0, block_count}, 128'd3);
    end
    chk("cnt_wrap", {126'b0, block_count}, 128'd0);
    chk("cnt_model", {126'b0, block_count}, {126'b0, exp_cnt});
    chk("scoreboard_empty", 128'(exp_state_q.size() + exp_out_q.size()), 128'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
